// File: rtl/seq_divider_if.sv
// ---------------------------------------------------------------------------
// seq_divider_if: request/response bundle for the sequential divider.
//   start    - request strobe, only accepted while the divider is idle
//   op       - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend - operand a, captured with start
//   divisor  - operand b, captured with start
//   busy     - divider is not idle
//   done     - one-cycle pulse, result valid in that cycle
//   result   - quotient or remainder selected by op, held until next done
// ---------------------------------------------------------------------------
interface seq_divider_if #(
    parameter int N = 32
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] result;

    modport master (
        output start, op, dividend, divisor,
        input  busy, done, result
    );

    modport slave (
        input  start, op, dividend, divisor,
        output busy, done, result
    );
endinterface

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider: multi-cycle restoring shift-subtract divider for the RISC-V
// DIV/DIVU/REM/REMU operations. One subtract/restore step per clock.
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - seq_divider_if slave (start/op/dividend/divisor in,
//         busy/done/result out)
// Normal ops finish with done in the cycle after edge k+N (k = capture edge);
// divide-by-zero and signed overflow finish in the cycle after edge k.
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int N = 32
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [N-1:0]  rem_q,    rem_d;
    logic [N-1:0]  quo_q,    quo_d;
    logic [N-1:0]  dvs_q,    dvs_d;     // |divisor|
    logic          neg_q_q,  neg_q_d;   // negate quotient
    logic          neg_r_q,  neg_r_d;   // negate remainder
    logic          sel_r_q,  sel_r_d;   // result is remainder
    logic          busy_q,   busy_d;
    logic          done_q,   done_d;
    logic [N-1:0]  result_q, result_d;

    // Capture-time operand decode
    logic         is_signed, a_neg, b_neg, div0, ovf;
    logic [N-1:0] a_abs, b_abs, spec_res;

    assign is_signed = ~bus.op[0];
    assign a_neg     = is_signed & bus.dividend[N-1];
    assign b_neg     = is_signed & bus.divisor[N-1];
    // Negating the most negative value gives the same bit pattern, which is
    // the correct magnitude when read as unsigned.
    assign a_abs     = a_neg ? -bus.dividend : bus.dividend;
    assign b_abs     = b_neg ? -bus.divisor  : bus.divisor;
    assign div0      = (bus.divisor == '0);
    assign ovf       = is_signed & (bus.dividend == {1'b1, {(N-1){1'b0}}})
                                 & (bus.divisor == '1);
    // Divide-by-zero takes priority over overflow.
    assign spec_res  = div0 ? (bus.op[1] ? bus.dividend : '1)
                            : (bus.op[1] ? '0 : bus.dividend);

    // One restoring step. The shifted remainder can need N+1 bits, so the
    // trial subtract carries an extra bit to keep its sign unambiguous.
    logic [N:0]   rem_sh;
    logic [N+1:0] diff;
    logic         ge;
    logic [N-1:0] rem_nx, quo_nx, quo_fix, rem_fix;

    assign rem_sh  = {rem_q, quo_q[N-1]};
    assign diff    = {1'b0, rem_sh} - {2'b00, dvs_q};
    assign ge      = ~diff[N+1];
    assign rem_nx  = ge ? diff[N-1:0] : rem_sh[N-1:0];
    assign quo_nx  = {quo_q[N-2:0], ge};
    assign quo_fix = neg_q_q ? -quo_nx : quo_nx;
    assign rem_fix = neg_r_q ? -rem_nx : rem_nx;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        sel_r_d  = sel_r_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    busy_d  = 1'b1;
                    sel_r_d = bus.op[1];
                    neg_q_d = a_neg ^ b_neg;
                    neg_r_d = a_neg;
                    dvs_d   = b_abs;
                    rem_d   = '0;
                    quo_d   = a_abs;
                    cnt_d   = '0;
                    if (div0 || ovf) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = spec_res;
                    end else begin
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = sel_r_q ? rem_fix : quo_fix;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            sel_r_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            sel_r_q  <= sel_r_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider: scoreboard bench for seq_divider (N=32). Expected results
// are queued when a request is driven and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_seq_divider;
    localparam int N = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   done_cnt;
    logic [N-1:0] exp_q[$];

    seq_divider_if #(.N(N)) bus();

    seq_divider #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    // Scoreboard: every done pops one expected result.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            done_cnt++;
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("result", bus.result, exp_q.pop_front());
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.dividend = a;
        bus.divisor  = b;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.done !== 1'b1 && lat < 100);
        chk("latency", 32'(lat), 32'(exp_lat));
        @(negedge clk);
        chk("busy_after_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int d0;
        checks       = 0;
        errors       = 0;
        done_cnt     = 0;
        bus.start    = 1'b0;
        bus.op       = 2'b00;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst          = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy",   32'(bus.busy), 32'd0);
        chk("rst_done",   32'(bus.done), 32'd0);
        chk("rst_result", bus.result,    32'd0);
        rst = 1'b0;

        // Normal operations: N+1 cycle latency
        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, N + 1);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, N + 1);
        do_op(2'b01, 32'd100, 32'd7, 32'd14, N + 1);
        do_op(2'b11, 32'd100, 32'd7, 32'd2, N + 1);
        do_op(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, N + 1);
        do_op(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, N + 1);
        do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, N + 1);
        // Special cases: 1-cycle latency
        do_op(2'b00, 32'd42, 32'd0, 32'hFFFF_FFFF, 1);
        do_op(2'b11, 32'd42, 32'd0, 32'd42, 1);
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, N + 1);

        // Starts during RUN (cycle 5) and during DONE (cycle 33) are ignored.
        d0 = done_cnt;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = 2'b01;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        exp_q.push_back(32'd14);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 5 || c == 33) begin
                bus.start    = 1'b1;
                bus.op       = 2'b00;
                bus.dividend = 32'h1234;
                bus.divisor  = 32'd5;
            end else begin
                bus.start = 1'b0;
            end
            if (c == 33) chk("hs_done_c33", 32'(bus.done), 32'd1);
            if (c == 34) begin
                chk("hs_busy_c34", 32'(bus.busy), 32'd0);
                chk("hs_done_c34", 32'(bus.done), 32'd0);
            end
        end
        chk("hs_one_done", 32'(done_cnt - d0), 32'd1);
        chk("hs_hold", bus.result, 32'd14);

        // Reset at iteration 10 discards the operation.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = 2'b00;
        bus.dividend = 32'hFFFF_FFF9;
        bus.divisor  = 32'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy",   32'(bus.busy), 32'd0);
        chk("mid_rst_done",   32'(bus.done), 32'd0);
        chk("mid_rst_result", bus.result,    32'd0);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);

        do_op(2'b01, 32'd9, 32'd3, 32'd3, N + 1);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
